// File: rtl/step_counter.sv
// Up/down step counter with wrap-or-saturate overflow, a wrap pulse and a sticky status flag; DOWN_COUNT_EN enables down counting.
// Latency 1 cycle from the enabling edge; there is no backpressure, so a step is accepted on every enabled cycle.
module step_counter #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] step,
    input  logic             dir,
    input  logic             mode,
    input  logic             clr_stat,
    output logic [WIDTH-1:0] count,
    output logic             stat,
    output logic             wrap
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   res;
    logic             over;
    logic [WIDTH-1:0] sat_val;
    logic [WIDTH-1:0] next_count;
    logic             next_wrap;
    logic             next_stat;

    assign sum = {1'b0, count} + {1'b0, step};

`ifdef DOWN_COUNT_EN
    logic [WIDTH:0] diff;
    assign diff    = {1'b0, count} - {1'b0, step};
    assign res     = dir ? diff : sum;
    // Bit WIDTH is the carry-out when adding and the borrow-out when subtracting.
    assign over    = res[WIDTH];
    assign sat_val = dir ? '0 : '1;
`else
    logic unused_dir;
    assign unused_dir = dir;
    assign res        = sum;
    assign over       = sum[WIDTH];
    assign sat_val    = '1;
`endif

    always_comb begin
        next_count = count;
        next_wrap  = 1'b0;
        next_stat  = stat & ~clr_stat;
        if (load) begin
            next_count = load_val;
        end else if (en) begin
            if (over) begin
                next_count = mode ? sat_val : res[WIDTH-1:0];
                next_wrap  = 1'b1;
                // A simultaneous clear loses to a fresh overflow/underflow.
                next_stat  = 1'b1;
            end else begin
                next_count = res[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RESET_VAL;
            wrap  <= 1'b0;
            stat  <= 1'b0;
        end else begin
            count <= next_count;
            wrap  <= next_wrap;
            stat  <= next_stat;
        end
    end

endmodule

// File: tb/tb_step_counter.sv
// Directed-vector bench for step_counter at WIDTH=8, RESET_VAL=0.
module tb_step_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] step;
    logic       dir;
    logic       mode;
    logic       clr_stat;
    logic [7:0] count;
    logic       stat;
    logic       wrap;

    int checks = 0;
    int fails  = 0;

    step_counter dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
        .step(step), .dir(dir), .mode(mode), .clr_stat(clr_stat),
        .count(count), .stat(stat), .wrap(wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 0; load = 0; clr_stat = 0; dir = 0; mode = 0;
    endtask

    task automatic do_load(input logic [7:0] v);
        idle();
        load = 1; load_val = v;
        tick();
        load = 0;
    endtask

    task automatic do_clear();
        idle();
        clr_stat = 1;
        tick();
        clr_stat = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; en = 0; load = 0; load_val = 0; step = 0; dir = 0; mode = 0; clr_stat = 0;
        #3;
        checks++; if (count !== 8'h00) begin fails++; $display("FAIL reset_count got=%h want=%h", count, 8'h00); end
        checks++; if (stat !== 1'b0) begin fails++; $display("FAIL reset_stat got=%b want=0", stat); end
        checks++; if (wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap got=%b want=0", wrap); end
        #20 rst_n = 1;
        tick();
    endtask

    task automatic test_async_reset();
        do_load(8'hFF);
        step = 1; en = 1;
        tick();
        do_load(8'h37);
        checks++; if (count !== 8'h37 || stat !== 1'b1) begin fails++; $display("FAIL areset_pre count=%h stat=%b want 37/1", count, stat); end
        en = 1; step = 8'h05;
        #2 rst_n = 0;
        #1;
        checks++; if (count !== 8'h00) begin fails++; $display("FAIL areset_count got=%h want=00", count); end
        checks++; if (stat !== 1'b0) begin fails++; $display("FAIL areset_stat got=%b want=0", stat); end
        checks++; if (wrap !== 1'b0) begin fails++; $display("FAIL areset_wrap got=%b want=0", wrap); end
        #1 rst_n = 1;
        #1;
        checks++; if (count !== 8'h00) begin fails++; $display("FAIL areset_hold got=%h want=00", count); end
        tick();
        checks++; if (count !== 8'h05) begin fails++; $display("FAIL areset_first_step got=%h want=05", count); end
        idle();
    endtask

    task automatic test_wrap();
        logic [7:0] exp_c [3];
        logic       exp_w [3];
        logic       exp_s [3];
        exp_c = '{8'hFF, 8'h00, 8'h01};
        exp_w = '{1'b0, 1'b1, 1'b0};
        exp_s = '{1'b0, 1'b1, 1'b1};
        do_clear();
        do_load(8'hFE);
        step = 1; mode = 0; en = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (count !== exp_c[i] || wrap !== exp_w[i] || stat !== exp_s[i]) begin
                fails++;
                $display("FAIL wrap_cycle%0d got c=%h w=%b s=%b want c=%h w=%b s=%b", i, count, wrap, stat, exp_c[i], exp_w[i], exp_s[i]);
            end
        end
        idle();
    endtask

    task automatic test_saturate();
        do_clear();
        do_load(8'hF0);
        step = 8'h20; mode = 1; en = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (count !== 8'hFF || wrap !== 1'b1 || stat !== 1'b1) begin
                fails++;
                $display("FAIL sat_cycle%0d got c=%h w=%b s=%b want c=ff w=1 s=1", i, count, wrap, stat);
            end
        end
        idle();
        tick();
        checks++; if (count !== 8'hFF || wrap !== 1'b0 || stat !== 1'b1) begin fails++; $display("FAIL sat_hold got c=%h w=%b s=%b want ff/0/1", count, wrap, stat); end
    endtask

    task automatic test_priority();
        do_load(8'h10);
        load = 1; en = 1; load_val = 8'h55; step = 1;
        tick();
        checks++; if (count !== 8'h55) begin fails++; $display("FAIL prio_count got=%h want=55", count); end
        checks++; if (wrap !== 1'b0 || stat !== 1'b1) begin fails++; $display("FAIL prio_flags got w=%b s=%b want 0/1", wrap, stat); end
        idle();
    endtask

    task automatic test_stat_race();
        do_clear();
        do_load(8'hFF);
        step = 1; mode = 0; en = 1; clr_stat = 1;
        tick();
        checks++; if (count !== 8'h00 || wrap !== 1'b1 || stat !== 1'b1) begin fails++; $display("FAIL race got c=%h w=%b s=%b want 00/1/1", count, wrap, stat); end
        en = 0;
        tick();
        checks++; if (stat !== 1'b0 || wrap !== 1'b0) begin fails++; $display("FAIL clr_stat got s=%b w=%b want 0/0", stat, wrap); end
        idle();
    endtask

    task automatic test_step_zero();
        do_load(8'hFF);
        step = 0; mode = 1; en = 1;
        tick();
        checks++; if (count !== 8'hFF || wrap !== 1'b0) begin fails++; $display("FAIL step0 got c=%h w=%b want ff/0", count, wrap); end
        idle();
    endtask

    task automatic test_direction();
        do_clear();
        do_load(8'h01);
        step = 2; dir = 1; mode = 0; en = 1;
        tick();
`ifdef DOWN_COUNT_EN
        checks++; if (count !== 8'hFF || stat !== 1'b1 || wrap !== 1'b1) begin fails++; $display("FAIL dir_wrap got c=%h s=%b w=%b want ff/1/1", count, stat, wrap); end
`else
        checks++; if (count !== 8'h03 || stat !== 1'b0 || wrap !== 1'b0) begin fails++; $display("FAIL dir_wrap got c=%h s=%b w=%b want 03/0/0", count, stat, wrap); end
`endif
        do_load(8'h01);
        step = 2; dir = 1; mode = 1; en = 1;
        tick();
`ifdef DOWN_COUNT_EN
        checks++; if (count !== 8'h00 || wrap !== 1'b1) begin fails++; $display("FAIL dir_sat got c=%h w=%b want 00/1", count, wrap); end
`else
        checks++; if (count !== 8'h03 || wrap !== 1'b0) begin fails++; $display("FAIL dir_sat got c=%h w=%b want 03/0", count, wrap); end
`endif
        idle();
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_wrap();
        test_saturate();
        test_priority();
        test_stat_race();
        test_step_zero();
        test_direction();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/step_counter.md
STEP_COUNTER -- requirements
Module: step_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter/step width in bits (legal >= 2).
REQ-002 SHALL have parameter RESET_VAL, default 0, count value loaded at reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  perform one step this cycle.
REQ-006 SHALL have port load  input  1  load load_val this cycle.
REQ-007 SHALL have port load_val  input  WIDTH  value for load.
REQ-008 SHALL have port step  input  WIDTH  unsigned increment/decrement amount.
REQ-009 SHALL have port dir  input  1  0 = up, 1 = down (see Configuration).
REQ-010 SHALL have port mode  input  1  0 = wrap on overflow, 1 = saturate.
REQ-011 SHALL have port clr_stat  input  1  clear sticky status.
REQ-012 SHALL have port count  output  WIDTH  registered counter value.
REQ-013 SHALL have port stat  output  1  sticky overflow/underflow flag, registered.
REQ-014 SHALL have port wrap  output  1  one-cycle registered pulse, overflow/underflow on last step.

Function
REQ-015 SHALL give load priority over en; load: count <= load_val, wrap <= 0, stat unchanged.
REQ-016 SHALL, with en=1, load=0, dir=0, compute count + step at WIDTH+1 bits; carry-out = overflow.
REQ-017 SHALL, with en=1, load=0, dir=1, compute count - step at WIDTH+1 bits; borrow-out = underflow.
REQ-018 SHALL, on no overflow/underflow, set count <= low WIDTH bits of result and wrap <= 0.
REQ-019 SHALL, on overflow/underflow with mode=0, set count <= low WIDTH bits of result (modular wrap-around).
REQ-020 SHALL, on overflow with mode=1, set count <= all ones; on underflow with mode=1, set count <= 0.
REQ-021 SHALL, on any overflow/underflow, set wrap <= 1 for exactly that cycle and stat <= 1.
REQ-022 SHALL treat a saturated count stepped again past its limit as a new overflow/underflow (wrap=1 again).
REQ-023 SHALL, with step = 0 and en=1, hold count with wrap <= 0.
REQ-024 SHALL, with en=0 and load=0, hold count and stat and drive wrap <= 0.
REQ-025 SHALL clear stat on clr_stat=1; set from a simultaneous overflow/underflow wins (stat stays 1).
REQ-026 SHALL show the updated count, wrap and stat one cycle after the enabling edge (latency 1).
REQ-027 SHALL sample mode and dir every cycle; no internal mode state.

Reset
REQ-028 SHALL, while rst_n=0, force count = RESET_VAL, stat = 0, wrap = 0 asynchronously, regardless of clk.
REQ-029 SHALL, when reset asserts mid-operation, discard any in-flight step; first update follows the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL honour dir (down counting per REQ-017/REQ-020) only when DOWN_COUNT_EN is defined.
REQ-031 SHALL, without DOWN_COUNT_EN, keep the dir port, ignore its value, and count up only; down-count logic is absent from the netlist.

Verification (WIDTH=8, RESET_VAL=0)
REQ-032 SHALL cover async reset: count=0x37, stat=1, rst_n pulled low between edges -> count=0x00, stat=0, wrap=0 before the next edge.
REQ-033 SHALL cover wrap mode: load 0xFE, step=1, mode=0, en for 3 cycles -> count 0xFF/0x00/0x01, wrap 0/1/0, stat 0/1/1.
REQ-034 SHALL cover saturate mode: load 0xF0, step=0x20, mode=1, en for 2 cycles -> count 0xFF/0xFF, wrap 1/1, stat 1.
REQ-035 SHALL cover priority: count=0x10, load=1, en=1, load_val=0x55, step=1 -> count=0x55, wrap=0, stat unchanged.
REQ-036 SHALL cover stat race: stat=0, count=0xFF, step=1, mode=0, en=1, clr_stat=1 -> count=0x00, wrap=1, stat=1.
REQ-037 SHALL cover direction: load 0x01, step=2, dir=1, mode=0, en -> with DOWN_COUNT_EN count=0xFF, stat=1; without it count=0x03, stat=0.
